addwm_job_ctrl: RTL and testbench
=================================

# addwm_job_ctrl

Job-level sequencer for the watermark-embedding kernel. It sits between the host control interface (ap_start/ap_idle/ap_done plus scalar arguments) and the two AXI engines: the image read/modify/write engine and the watermark reader. It latches and validates the job arguments, starts the watermark reader ahead of the image engine, collects both completions in any order, and reports done with sticky error status.

## Interface

Parameters:
- C_XFER_SIZE_WIDTH, 32, width of all length arguments
- C_ADDR_WIDTH, 64, width of buffer base addresses
- C_TIMEOUT_WIDTH, 32, width of the timeout counter and limit
- C_WM_LEAD_CYCLES, 4, cycles between wm_start and im_start; 0 means no lead

Ports:
- ap_clk  in  1  clock
- areset  in  1  reset, synchronous, active-high
- ap_start  in  1  host start level
- ap_idle  out  1  kernel idle
- ap_done  out  1  job complete, one-cycle pulse
- p00  in  32  watermark strength
- p01  in  C_XFER_SIZE_WIDTH  image read length, bytes
- p10  in  C_XFER_SIZE_WIDTH  image write length, bytes
- p11  in  C_XFER_SIZE_WIDTH  watermark read length, bytes
- axi00_im  in  C_ADDR_WIDTH  image buffer base
- axi01_wm  in  C_ADDR_WIDTH  watermark buffer base
- timeout_limit  in  C_TIMEOUT_WIDTH  cycle budget per job; 0 disables the timeout
- cfg_strength, cfg_im_rd_len, cfg_im_wr_len, cfg_wm_rd_len, cfg_im_addr, cfg_wm_addr  out  matching widths  latched arguments, stable from LATCH until the next LATCH
- wm_start  out  1  watermark reader start pulse
- im_start  out  1  image engine start pulse
- wm_done  in  1  watermark reader done pulse
- im_done  in  1  image engine done pulse
- err_cfg  out  1  sticky: arguments rejected
- err_timeout  out  1  sticky: budget exceeded

## Operation

- Start detection: ap_start_r is a flop of ap_start with reset 0. start_pulse = ap_start & ~ap_start_r. start_pulse is honoured only in IDLE and ignored in all other states. ap_start held high produces no new job.
- State machine, one-hot or enum:
  - IDLE: on start_pulse, go to LATCH.
  - LATCH: register all p*/axi* into cfg_*. Clear err_cfg, err_timeout, both done flags and the timeout counter. Go to CHECK.
  - CHECK: validate the latched arguments, then go to WM_GO if valid; otherwise set err_cfg and go to DONE without starting either engine.
  - WM_GO: wm_start=1 for one cycle. Go to LEAD, or to IM_GO if C_WM_LEAD_CYCLES=0.
  - LEAD: count C_WM_LEAD_CYCLES cycles, then go to IM_GO.
  - IM_GO: im_start=1 for one cycle. Go to WAIT.
  - WAIT: go to DONE when both done flags are set.
  - DONE: ap_done=1 for one cycle. Go to IDLE.
- Validity rules, all must hold:
  - p01 is nonzero and a multiple of 64.
  - p10 equals p01.
  - p11 is nonzero and a multiple of 16.
  - axi00_im is 64-byte aligned.
  - axi01_wm is 16-byte aligned.
- Done flags: wm_done_f and im_done_f are set by their pulses in WM_GO, LEAD, IM_GO and WAIT. Pulses may arrive in either order, in the same cycle, or before im_start (wm finishing during LEAD). Pulses in IDLE, LATCH, CHECK or DONE are ignored.
- Timeout: the counter increments each cycle in WM_GO through WAIT and saturates at its maximum. If timeout_limit≠0 and counter == timeout_limit−1 while not yet complete: set err_timeout and go to DONE. The engines are not aborted, and their late done pulses are ignored. If completion and timeout occur in the same cycle, completion wins and err_timeout stays 0.
- Width rules: the length checks use the low 6 or 4 bits only. No arithmetic is performed on the lengths.

## Timing

- Reset values:
  - state IDLE, ap_idle=1, ap_done=0, wm_start=0, im_start=0.
  - err_cfg=0, err_timeout=0, cfg_*=0, ap_start_r=0.
- Reset mid-job returns every flop to its reset value immediately. No start or done pulse is emitted afterwards.
- All outputs are registered or decoded from the state flop; none is combinational from inputs.
- Cycle numbering, with start_pulse in cycle 0:
  - cycle 1: LATCH, ap_idle=0
  - cycle 2: CHECK
  - cycle 3: wm_start
  - cycle 4+L: im_start, where L = C_WM_LEAD_CYCLES
- A completion flag set in cycle N causes DONE, and therefore ap_done, in cycle N+1. ap_idle returns to 1 in cycle N+2.
- Config reject: ap_done in cycle 3, ap_idle=1 in cycle 4, no engine starts.
- ap_idle falls the cycle after start_pulse and rises the cycle after ap_done.

## Structure

- Shared package addwm_pkg holds:
  - the state enum addwm_job_state_t
  - LP_IM_BEAT_BYTES=64 and LP_WM_BEAT_BYTES=16
- A single module. The only sub-module is addwm_pulse_latch (set-on-pulse, clear-on-LATCH, enable window), instantiated twice for the done flags.

## Test plan

- Valid job (p01=p10=16384, p11=4096, aligned bases, L=4): start at cycle 0 → wm_start at cycle 3, im_start at cycle 8. With im_done at 40 and wm_done at 50, ap_done=1 at 51 and ap_idle=1 at 52.
- Done ordering: wm_done in LEAD, im_done and wm_done in the same cycle, and im_done first each produce exactly one ap_done, one cycle after the second flag sets.
- Config reject: p10=8192 with p01=16384, or axi01_wm=0x…08 → err_cfg=1, no wm_start/im_start, ap_done at cycle 3.
- Timeout: timeout_limit=100 with im_done never asserted → err_timeout=1, ap_done once. A later im_done is ignored; err_timeout clears at the next job's LATCH.
- ap_start held high across ap_done → no second job. A start pulse during WAIT → ignored, cfg_* unchanged.
- areset asserted in WAIT → next cycle ap_idle=1, all outputs 0. A new start behaves exactly as in the valid-job case.

Source files
------------

// File: rtl/addwm_pkg.sv
// rtl/addwm_pkg.sv - shared types and beat geometry for the watermark kernel
package addwm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_CHECK,
    ST_WM_GO,
    ST_LEAD,
    ST_IM_GO,
    ST_WAIT,
    ST_DONE
  } addwm_job_state_t;

  localparam int LP_IM_BEAT_BYTES = 64;
  localparam int LP_WM_BEAT_BYTES = 16;
  localparam int LP_IM_ALIGN_BITS = $clog2(LP_IM_BEAT_BYTES);
  localparam int LP_WM_ALIGN_BITS = $clog2(LP_WM_BEAT_BYTES);

endpackage

// File: rtl/addwm_job_ctrl_if.sv
// rtl/addwm_job_ctrl_if.sv - host control and engine start/done handshake bundle
interface addwm_job_ctrl_if;

  logic ap_start;
  logic ap_idle;
  logic ap_done;
  logic wm_start;
  logic im_start;
  logic wm_done;
  logic im_done;
  logic err_cfg;
  logic err_timeout;

  modport slave (
    input  ap_start, wm_done, im_done,
    output ap_idle, ap_done, wm_start, im_start, err_cfg, err_timeout
  );

  modport master (
    output ap_start, wm_done, im_done,
    input  ap_idle, ap_done, wm_start, im_start, err_cfg, err_timeout
  );

endinterface

// File: rtl/addwm_pulse_latch.sv
// rtl/addwm_pulse_latch.sv - sticky done flag: set by pulse inside window, cleared on clr
module addwm_pulse_latch (
  input  logic ap_clk,
  input  logic areset,
  input  logic clr,
  input  logic en,
  input  logic pulse,
  output logic flag,
  output logic seen
);

  always_ff @(posedge ap_clk) begin
    if (areset || clr) begin
      flag <= 1'b0;
    end else if (en && pulse) begin
      flag <= 1'b1;
    end
  end

  // seen includes this cycle's pulse so completion can advance the FSM without a cycle of lag
  assign seen = flag | (en & pulse);

endmodule

// File: rtl/addwm_job_ctrl.sv
// rtl/addwm_job_ctrl.sv - job sequencer: latch/validate args, start wm then im, collect dones
module addwm_job_ctrl
  import addwm_pkg::*;
#(
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_TIMEOUT_WIDTH   = 32,
  parameter int C_WM_LEAD_CYCLES  = 4
) (
  input  logic                         ap_clk,
  input  logic                         areset,
  addwm_job_ctrl_if.slave              ctl,
  input  logic [31:0]                  p00,
  input  logic [C_XFER_SIZE_WIDTH-1:0] p01,
  input  logic [C_XFER_SIZE_WIDTH-1:0] p10,
  input  logic [C_XFER_SIZE_WIDTH-1:0] p11,
  input  logic [C_ADDR_WIDTH-1:0]      axi00_im,
  input  logic [C_ADDR_WIDTH-1:0]      axi01_wm,
  input  logic [C_TIMEOUT_WIDTH-1:0]   timeout_limit,
  output logic [31:0]                  cfg_strength,
  output logic [C_XFER_SIZE_WIDTH-1:0] cfg_im_rd_len,
  output logic [C_XFER_SIZE_WIDTH-1:0] cfg_im_wr_len,
  output logic [C_XFER_SIZE_WIDTH-1:0] cfg_wm_rd_len,
  output logic [C_ADDR_WIDTH-1:0]      cfg_im_addr,
  output logic [C_ADDR_WIDTH-1:0]      cfg_wm_addr
);

  localparam int LEAD_W = (C_WM_LEAD_CYCLES > 1) ? $clog2(C_WM_LEAD_CYCLES) : 1;
  localparam logic [LEAD_W-1:0]          LEAD_LAST = LEAD_W'(C_WM_LEAD_CYCLES - 1);
  localparam logic [LEAD_W-1:0]          LEAD_ONE  = LEAD_W'(1);
  localparam logic [C_TIMEOUT_WIDTH-1:0] TMO_ONE   = C_TIMEOUT_WIDTH'(1);
  localparam bit                         HAS_LEAD  = (C_WM_LEAD_CYCLES != 0);

  addwm_job_state_t state, state_next;

  logic                       ap_start_r;
  logic                       start_pulse;
  logic                       err_cfg_q, err_tmo_q;
  logic                       err_cfg_set, err_tmo_set;
  logic [C_TIMEOUT_WIDTH-1:0] tmo_cnt;
  logic [LEAD_W-1:0]          lead_cnt;
  logic                       engine_window, latching;
  logic                       wm_flag, im_flag, wm_seen, im_seen, both_seen;
  logic                       args_ok, tmo_hit, lead_last;

  assign start_pulse   = ctl.ap_start & ~ap_start_r;
  assign latching      = (state == ST_LATCH);
  assign engine_window = (state == ST_WM_GO) || (state == ST_LEAD) ||
                         (state == ST_IM_GO) || (state == ST_WAIT);
  assign both_seen     = wm_seen & im_seen;
  assign lead_last     = (lead_cnt == LEAD_LAST);
  assign tmo_hit       = (timeout_limit != '0) && (tmo_cnt == timeout_limit - TMO_ONE);

  // Only the low alignment bits matter; lengths never feed arithmetic
  assign args_ok = (cfg_im_rd_len != '0) && (cfg_im_rd_len[LP_IM_ALIGN_BITS-1:0] == '0) &&
                   (cfg_im_wr_len == cfg_im_rd_len) &&
                   (cfg_wm_rd_len != '0) && (cfg_wm_rd_len[LP_WM_ALIGN_BITS-1:0] == '0) &&
                   (cfg_im_addr[LP_IM_ALIGN_BITS-1:0] == '0) &&
                   (cfg_wm_addr[LP_WM_ALIGN_BITS-1:0] == '0);

  addwm_pulse_latch u_wm_done (
    .ap_clk (ap_clk), .areset (areset), .clr (latching), .en (engine_window),
    .pulse  (ctl.wm_done), .flag (wm_flag), .seen (wm_seen)
  );

  addwm_pulse_latch u_im_done (
    .ap_clk (ap_clk), .areset (areset), .clr (latching), .en (engine_window),
    .pulse  (ctl.im_done), .flag (im_flag), .seen (im_seen)
  );

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state         <= ST_IDLE;
      ap_start_r    <= 1'b0;
      err_cfg_q     <= 1'b0;
      err_tmo_q     <= 1'b0;
      tmo_cnt       <= '0;
      lead_cnt      <= '0;
      cfg_strength  <= '0;
      cfg_im_rd_len <= '0;
      cfg_im_wr_len <= '0;
      cfg_wm_rd_len <= '0;
      cfg_im_addr   <= '0;
      cfg_wm_addr   <= '0;
    end else begin
      state      <= state_next;
      ap_start_r <= ctl.ap_start;
      lead_cnt   <= (state == ST_LEAD) ? lead_cnt + LEAD_ONE : '0;
      if (latching) begin
        cfg_strength  <= p00;
        cfg_im_rd_len <= p01;
        cfg_im_wr_len <= p10;
        cfg_wm_rd_len <= p11;
        cfg_im_addr   <= axi00_im;
        cfg_wm_addr   <= axi01_wm;
        err_cfg_q     <= 1'b0;
        err_tmo_q     <= 1'b0;
        tmo_cnt       <= '0;
      end else begin
        if (err_cfg_set) err_cfg_q <= 1'b1;
        if (err_tmo_set) err_tmo_q <= 1'b1;
        if (engine_window && (tmo_cnt != '1)) tmo_cnt <= tmo_cnt + TMO_ONE;
      end
    end
  end

  always_comb begin
    state_next  = state;
    err_cfg_set = 1'b0;
    err_tmo_set = 1'b0;
    case (state)
      ST_IDLE:  if (start_pulse) state_next = ST_LATCH;
      ST_LATCH: state_next = ST_CHECK;
      ST_CHECK: begin
        if (args_ok) begin
          state_next = ST_WM_GO;
        end else begin
          state_next  = ST_DONE;
          err_cfg_set = 1'b1;
        end
      end
      ST_WM_GO: state_next = HAS_LEAD ? ST_LEAD : ST_IM_GO;
      ST_LEAD:  if (lead_last) state_next = ST_IM_GO;
      ST_IM_GO: state_next = ST_WAIT;
      ST_WAIT:  if (both_seen) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    // Completion in the same cycle beats the budget
    if (engine_window && tmo_hit && !both_seen) begin
      state_next  = ST_DONE;
      err_tmo_set = 1'b1;
    end
  end

  assign ctl.ap_idle     = (state == ST_IDLE);
  assign ctl.ap_done     = (state == ST_DONE);
  assign ctl.wm_start    = (state == ST_WM_GO);
  assign ctl.im_start    = (state == ST_IM_GO);
  assign ctl.err_cfg     = err_cfg_q;
  assign ctl.err_timeout = err_tmo_q;

endmodule

// File: tb/tb_addwm_job_ctrl.sv
// tb/tb_addwm_job_ctrl.sv - scoreboard bench for addwm_job_ctrl
module tb_addwm_job_ctrl;

  localparam int EV_WM = 0, EV_IM = 1, EV_DONE = 2, EV_IDLE = 3;

  typedef struct {
    int kind;
    int cyc;
    bit ecfg;
    bit etmo;
  } ev_t;

  logic        ap_clk = 1'b0;
  logic        areset;
  logic [31:0] p00, p01, p10, p11, timeout_limit;
  logic [63:0] axi00_im, axi01_wm;
  logic [31:0] cfg_strength, cfg_im_rd_len, cfg_im_wr_len, cfg_wm_rd_len;
  logic [63:0] cfg_im_addr, cfg_wm_addr;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];
  logic idle_prev = 1'b1;

  addwm_job_ctrl_if ctl ();

  addwm_job_ctrl dut (
    .ap_clk        (ap_clk),
    .areset        (areset),
    .ctl           (ctl),
    .p00           (p00),
    .p01           (p01),
    .p10           (p10),
    .p11           (p11),
    .axi00_im      (axi00_im),
    .axi01_wm      (axi01_wm),
    .timeout_limit (timeout_limit),
    .cfg_strength  (cfg_strength),
    .cfg_im_rd_len (cfg_im_rd_len),
    .cfg_im_wr_len (cfg_im_wr_len),
    .cfg_wm_rd_len (cfg_wm_rd_len),
    .cfg_im_addr   (cfg_im_addr),
    .cfg_wm_addr   (cfg_wm_addr)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input bit ecfg, input bit etmo);
    ev_t e;
    e.kind = kind; e.cyc = c; e.ecfg = ecfg; e.etmo = etmo;
    exp_q.push_back(e);
  endtask

  task automatic push_valid(input int t0, input int dn);
    push(EV_WM, t0 + 3, 0, 0);
    push(EV_IM, t0 + 8, 0, 0);
    push(EV_DONE, t0 + dn, 0, 0);
    push(EV_IDLE, t0 + dn + 1, 0, 0);
  endtask

  task automatic sb_check(input int kind);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got event %0d at cycle %0d, expected none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc ||
          (kind == EV_DONE && (e.ecfg != ctl.err_cfg || e.etmo != ctl.err_timeout))) begin
        n_fail++;
        $display("FAIL sb_event: got kind %0d cyc %0d cfg %0b tmo %0b, expected kind %0d cyc %0d cfg %0b tmo %0b",
                 kind, cyc, ctl.err_cfg, ctl.err_timeout, e.kind, e.cyc, e.ecfg, e.etmo);
      end
    end
  endtask

  always @(negedge ap_clk) begin
    if (ctl.wm_start === 1'b1) sb_check(EV_WM);
    if (ctl.im_start === 1'b1) sb_check(EV_IM);
    if (ctl.ap_done === 1'b1) sb_check(EV_DONE);
    if (ctl.ap_idle === 1'b1 && idle_prev === 1'b0) sb_check(EV_IDLE);
    idle_prev <= ctl.ap_idle;
  end

  task automatic goto(input int n);
    if (cyc > n) chk("schedule", cyc, n);
    while (cyc < n) begin
      @(posedge ap_clk);
      #1;
    end
  endtask

  task automatic start_job(input int t0);
    goto(t0);
    ctl.ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ctl.ap_start = 1'b0;
  endtask

  task automatic pulse(input int n, input bit wm, input bit im);
    goto(n);
    ctl.wm_done = wm;
    ctl.im_done = im;
    @(posedge ap_clk); #1;
    ctl.wm_done = 1'b0;
    ctl.im_done = 1'b0;
  endtask

  task automatic set_valid();
    p00 = 32'h33; p01 = 32'd16384; p10 = 32'd16384; p11 = 32'd4096;
    axi00_im = 64'h0000_0001_0000_0000;
    axi01_wm = 64'h0000_0002_0000_0040;
    timeout_limit = 32'd0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_idle"}, ctl.ap_idle, 1);
    chk({tag, "_done"}, ctl.ap_done, 0);
    chk({tag, "_starts"}, {ctl.wm_start, ctl.im_start}, 0);
    chk({tag, "_errs"}, {ctl.err_cfg, ctl.err_timeout}, 0);
    chk({tag, "_cfg"}, {cfg_im_rd_len, cfg_wm_addr}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: cycle %0d reached time limit", cyc);
    $fatal(1);
  end

  initial begin
    areset = 1'b1;
    ctl.ap_start = 1'b0; ctl.wm_done = 1'b0; ctl.im_done = 1'b0;
    set_valid();
    repeat (3) @(posedge ap_clk);
    #1;
    chk_idle_outputs("reset");
    areset = 1'b0;

    // valid job with reference timing
    push_valid(10, 51);
    start_job(10);
    chk("a_idle_latch", ctl.ap_idle, 0);
    goto(12);
    chk("a_cfg_len", {cfg_im_rd_len, cfg_im_wr_len}, {32'd16384, 32'd16384});
    chk("a_cfg_wm", {cfg_wm_rd_len, cfg_strength}, {32'd4096, 32'h33});
    chk("a_cfg_im_addr", cfg_im_addr, 64'h0000_0001_0000_0000);
    pulse(50, 0, 1);
    pulse(60, 1, 0);

    // wm done during the lead window
    push_valid(100, 21);
    start_job(100);
    pulse(105, 1, 0);
    pulse(120, 0, 1);

    // both dones in the same cycle
    push_valid(140, 16);
    start_job(140);
    pulse(155, 1, 1);

    // im first, plus a start pulse during WAIT with different arguments
    push_valid(180, 26);
    start_job(180);
    pulse(192, 0, 1);
    goto(195);
    p00 = 32'h7; p01 = 32'd128;
    ctl.ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ctl.ap_start = 1'b0;
    goto(197);
    chk("d_cfg_hold", {cfg_strength, cfg_im_rd_len}, {32'h33, 32'd16384});
    set_valid();
    pulse(205, 1, 0);

    // write length mismatch
    p10 = 32'd8192;
    push(EV_DONE, 233, 1, 0);
    push(EV_IDLE, 234, 0, 0);
    start_job(230);
    goto(240);
    set_valid();

    // misaligned watermark base
    axi01_wm = 64'h0000_0002_0000_0008;
    push(EV_DONE, 253, 1, 0);
    push(EV_IDLE, 254, 0, 0);
    start_job(250);
    goto(260);
    set_valid();

    // timeout with im_done never arriving in time
    timeout_limit = 32'd100;
    push(EV_WM, 273, 0, 0);
    push(EV_IM, 278, 0, 0);
    push(EV_DONE, 373, 0, 1);
    push(EV_IDLE, 374, 0, 0);
    start_job(270);
    pulse(290, 1, 0);
    pulse(380, 0, 1);
    timeout_limit = 32'd0;

    // next job clears err_timeout at LATCH
    push_valid(400, 13);
    start_job(400);
    chk("h_tmo_before_latch", ctl.err_timeout, 1);
    goto(402);
    chk("h_tmo_cleared", ctl.err_timeout, 0);
    pulse(410, 0, 1);
    pulse(412, 1, 0);

    // ap_start held high across ap_done
    push_valid(440, 12);
    goto(440);
    ctl.ap_start = 1'b1;
    pulse(450, 0, 1);
    pulse(451, 1, 0);
    goto(480);
    ctl.ap_start = 1'b0;

    // reset while in WAIT
    push(EV_WM, 493, 0, 0);
    push(EV_IM, 498, 0, 0);
    push(EV_IDLE, 506, 0, 0);
    start_job(490);
    goto(505);
    areset = 1'b1;
    goto(506);
    chk_idle_outputs("rst_wait");
    areset = 1'b0;
    pulse(510, 1, 1);

    // fresh job after reset matches the reference timing
    push_valid(520, 51);
    start_job(520);
    pulse(560, 0, 1);
    pulse(570, 1, 0);

    goto(600);
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
